// File: rtl/mem_rr_arbiter_pkg.sv
// Shared types and constants for the SRAM round-robin arbiter.
// Holds the data/byte-enable widths, the winner payload struct and the
// port-index width helper.
package mem_arb_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned BE_WIDTH       = 4;
  // Upper bound for the address field carried in the payload struct.
  localparam int unsigned MAX_ADDR_WIDTH = 64;

  // One SRAM access as presented by the winning requester.
  typedef struct packed {
    logic [MAX_ADDR_WIDTH-1:0] addr;
    logic                      we;
    logic [BE_WIDTH-1:0]       be;
    logic [DATA_WIDTH-1:0]     wdata;
  } mem_req_t;

  // Bits needed to index n ports.
  function automatic int unsigned port_idx_w(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/mem_rr_arbiter_if.sv
// Requester and SRAM side signals of the round-robin arbiter.
//   slave  : arbiter view (takes requests and SRAM data, drives grants/SRAM)
//   master : environment view (requesters plus SRAM macro)
// Per-port fields are packed arrays indexed by port number.
interface mem_rr_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned ADDR_WIDTH = 32
) ();

  logic [NUM_PORTS-1:0]                      req_i;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]      addr_i;
  logic [NUM_PORTS-1:0]                      we_i;
  logic [NUM_PORTS-1:0][BE_WIDTH-1:0]        be_i;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]      wdata_i;
  logic [NUM_PORTS-1:0]                      gnt_o;
  logic [NUM_PORTS-1:0]                      rvalid_o;
  logic [DATA_WIDTH-1:0]                     rdata_o;

  logic                                      mem_req_o;
  logic [ADDR_WIDTH-1:0]                     mem_addr_o;
  logic                                      mem_we_o;
  logic [BE_WIDTH-1:0]                       mem_be_o;
  logic [DATA_WIDTH-1:0]                     mem_wdata_o;
  logic                                      mem_gnt_i;
  logic [DATA_WIDTH-1:0]                     mem_rdata_i;

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i, mem_gnt_i, mem_rdata_i,
    output gnt_o, rvalid_o, rdata_o,
           mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
  );

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i, mem_gnt_i, mem_rdata_i,
    input  gnt_o, rvalid_o, rdata_o,
           mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
  );

endinterface

// File: rtl/mem_rr_arbiter_rr_find_first.sv
// Round-robin search: first set bit of req_i starting at ptr_i and wrapping
// at NUM_PORTS-1 (works for non power-of-two port counts).
//   req_i   : request vector
//   ptr_i   : search start index, must be < NUM_PORTS
//   idx_o   : index of the first requester found (0 when none)
//   valid_o : at least one request present
module rr_find_first
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  localparam int unsigned PW       = port_idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [PW-1:0]        ptr_i,
  output logic [PW-1:0]        idx_o,
  output logic                 valid_o
);

  // Walk candidates ptr, ptr+1, ... mod NUM_PORTS; keep the first hit.
  always_comb begin : search
    int unsigned cand;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = 32'(ptr_i) + i;
      if (cand >= NUM_PORTS) begin
        cand = cand - NUM_PORTS;
      end
      if (!valid_o && req_i[PW'(cand)]) begin
        valid_o = 1'b1;
        idx_o   = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM (1-cycle read latency)
// among NUM_PORTS requesters with a req/gnt/rvalid protocol.
//   clk, rst : clock (posedge) and async active-high reset
//   bus      : requester ports (req/addr/we/be/wdata in, gnt/rvalid/rdata out)
//              and SRAM ports (mem_req/addr/we/be/wdata out, mem_gnt/rdata in)
// Grant is combinational from the current requests; rvalid follows the grant
// by exactly one cycle and read data passes straight through from the SRAM.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_rr_arbiter_if.slave      bus
);

  localparam int unsigned PW = port_idx_w(NUM_PORTS);

  logic [PW-1:0] rr_ptr_q;
  logic [PW-1:0] ptr_nxt;
  logic          rvalid_q;
  logic [PW-1:0] port_q;

  logic [PW-1:0] win_idx;
  logic          win_valid;
  logic          active;
  logic          grant;
  mem_req_t      win;
  logic          unused_addr;

  rr_find_first #(
    .NUM_PORTS (NUM_PORTS)
  ) u_find (
    .req_i   (bus.req_i),
    .ptr_i   (rr_ptr_q),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  // Nothing reaches the SRAM or the requesters while reset is held.
  assign active = win_valid & ~rst;
  assign grant  = active & bus.mem_gnt_i;

  // Pointer moves just past the winner, wrapping explicitly.
  assign ptr_nxt = (win_idx == PW'(NUM_PORTS - 1)) ? '0 : win_idx + PW'(1);

  // Winner payload mux; all-zero when idle.
  always_comb begin
    win = '0;
    if (active) begin
      win.addr  = MAX_ADDR_WIDTH'(bus.addr_i[win_idx]);
      win.we    = bus.we_i[win_idx];
      win.be    = bus.be_i[win_idx];
      win.wdata = bus.wdata_i[win_idx];
    end
  end

  assign bus.mem_req_o   = active;
  assign bus.mem_addr_o  = win.addr[ADDR_WIDTH-1:0];
  assign bus.mem_we_o    = win.we;
  assign bus.mem_be_o    = win.be;
  assign bus.mem_wdata_o = win.wdata;
  assign unused_addr     = ^win.addr;

  // One-hot grant to the winner when the SRAM accepts.
  always_comb begin
    bus.gnt_o = '0;
    if (grant) begin
      bus.gnt_o[win_idx] = 1'b1;
    end
  end

  // Response strobe routed back to the port granted last cycle.
  always_comb begin
    bus.rvalid_o         = '0;
    bus.rvalid_o[port_q] = rvalid_q;
  end

  assign bus.rdata_o = bus.mem_rdata_i;

  // Pointer and in-flight response tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      rvalid_q <= 1'b0;
      port_q   <= '0;
    end else begin
      rvalid_q <= grant;
      if (grant) begin
        rr_ptr_q <= ptr_nxt;
        port_q   <= win_idx;
      end
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter with NUM_PORTS=4: a per-cycle vector
// table for arbitration order and SRAM back-pressure, plus hand sequences for
// single-port streaming reads, partial writes and reset mid-access.
module tb_mem_rr_arbiter;

  localparam int unsigned NP = 4;
  localparam int unsigned AW = 32;

  logic clk;
  logic rst;

  mem_rr_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW)) bus ();

  mem_rr_arbiter #(
    .NUM_PORTS  (NP),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: 256 words, 1-cycle read latency, byte-enabled writes.
  logic [31:0] mem [0:255];
  logic [31:0] rdata_q;
  assign bus.mem_rdata_i = rdata_q;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[64]  <= 32'hA5A5_0001;   // 0x100
      mem[65]  <= 32'hA5A5_0002;   // 0x104
      mem[16]  <= 32'h1234_5678;   // 0x40
      mem[128] <= 32'h1111_0000;   // 0x200
      mem[129] <= 32'h1111_0001;
      mem[130] <= 32'h1111_0002;
      mem[131] <= 32'h1111_0003;
      rdata_q  <= 32'h0;
    end else if (bus.mem_req_o && bus.mem_gnt_i) begin
      if (bus.mem_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.mem_be_o[b]) mem[bus.mem_addr_o[9:2]][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
        end
      end else begin
        rdata_q <= mem[bus.mem_addr_o[9:2]];
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_port(input logic [1:0] p, input logic r, input logic [31:0] a,
                          input logic w, input logic [3:0] b, input logic [31:0] d);
    bus.req_i[p]   = r;
    bus.addr_i[p]  = a;
    bus.we_i[p]    = w;
    bus.be_i[p]    = b;
    bus.wdata_i[p] = d;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic        mgnt;
    logic [3:0]  exp_gnt;
    logic [3:0]  exp_rvalid;
    logic        exp_mreq;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [19];

  initial begin
    // all four requesting from rr_ptr=0: strict rotation
    vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 4'b0000, 1'b1, 32'h0};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 4'b0001, 1'b1, 32'h1111_0000};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 4'b0010, 1'b1, 32'h1111_0001};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 4'b0100, 1'b1, 32'h1111_0002};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 4'b1000, 1'b1, 32'h1111_0003};
    vecs[5]  = '{4'b1111, 1'b1, 4'b0010, 4'b0001, 1'b1, 32'h1111_0000};
    vecs[6]  = '{4'b1111, 1'b1, 4'b0100, 4'b0010, 1'b1, 32'h1111_0001};
    vecs[7]  = '{4'b1111, 1'b1, 4'b1000, 4'b0100, 1'b1, 32'h1111_0002};
    // port 1 alone moves rr_ptr to 2; then ports 1,3 alternate starting at 3
    vecs[8]  = '{4'b0010, 1'b1, 4'b0010, 4'b1000, 1'b1, 32'h1111_0003};
    vecs[9]  = '{4'b1010, 1'b1, 4'b1000, 4'b0010, 1'b1, 32'h1111_0001};
    vecs[10] = '{4'b1010, 1'b1, 4'b0010, 4'b1000, 1'b1, 32'h1111_0003};
    vecs[11] = '{4'b1010, 1'b1, 4'b1000, 4'b0010, 1'b1, 32'h1111_0001};
    vecs[12] = '{4'b0000, 1'b1, 4'b0000, 4'b1000, 1'b0, 32'h1111_0003};
    // SRAM stalls 3 cycles: no grant, pointer must stay at 0
    vecs[13] = '{4'b0011, 1'b0, 4'b0000, 4'b0000, 1'b1, 32'h0};
    vecs[14] = '{4'b0011, 1'b0, 4'b0000, 4'b0000, 1'b1, 32'h0};
    vecs[15] = '{4'b0011, 1'b0, 4'b0000, 4'b0000, 1'b1, 32'h0};
    vecs[16] = '{4'b0011, 1'b1, 4'b0001, 4'b0000, 1'b1, 32'h0};
    vecs[17] = '{4'b0011, 1'b1, 4'b0010, 4'b0001, 1'b1, 32'h1111_0000};
    vecs[18] = '{4'b0000, 1'b1, 4'b0000, 4'b0010, 1'b0, 32'h1111_0001};
  end

  initial begin
    rst = 1'b1;
    bus.mem_gnt_i = 1'b1;
    for (int p = 0; p < 4; p++) set_port(2'(p), 1'b1, 32'h200 + 32'(4 * p), 1'b1, 4'hF, 32'h0);

    // reset held with every port requesting a write
    @(negedge clk);
    #1;
    check("reset gnt", 32'(bus.gnt_o), 32'h0);
    check("reset rvalid", 32'(bus.rvalid_o), 32'h0);
    check("reset mem_req", 32'(bus.mem_req_o), 32'h0);
    check("reset mem_we", 32'(bus.mem_we_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int p = 0; p < 4; p++) set_port(2'(p), 1'b0, 32'h200 + 32'(4 * p), 1'b0, 4'hF, 32'h0);

    // table: one row per cycle, rvalid/rdata reflect the previous row's grant
    for (int i = 0; i < 19; i++) begin
      bus.req_i     = vecs[i].req;
      bus.mem_gnt_i = vecs[i].mgnt;
      #1;
      check($sformatf("vec%0d gnt", i), 32'(bus.gnt_o), 32'(vecs[i].exp_gnt));
      check($sformatf("vec%0d rvalid", i), 32'(bus.rvalid_o), 32'(vecs[i].exp_rvalid));
      check($sformatf("vec%0d mem_req", i), 32'(bus.mem_req_o), 32'(vecs[i].exp_mreq));
      if (vecs[i].exp_rvalid != 4'b0000)
        check($sformatf("vec%0d rdata", i), bus.rdata_o, vecs[i].exp_rdata);
      if (!vecs[i].exp_mreq)
        check($sformatf("vec%0d idle mem_we", i), 32'(bus.mem_we_o), 32'h0);
      @(negedge clk);
    end
    bus.mem_gnt_i = 1'b1;

    // port 0 streams two reads back to back
    set_port(2'd0, 1'b1, 32'h100, 1'b0, 4'hF, 32'h0);
    #1;
    check("rd1 gnt", 32'(bus.gnt_o), 32'h1);
    check("rd1 mem_addr", bus.mem_addr_o, 32'h100);
    @(negedge clk);
    set_port(2'd0, 1'b1, 32'h104, 1'b0, 4'hF, 32'h0);
    #1;
    check("rd2 gnt", 32'(bus.gnt_o), 32'h1);
    check("rd1 rvalid", 32'(bus.rvalid_o), 32'h1);
    check("rd1 rdata", bus.rdata_o, 32'hA5A5_0001);
    @(negedge clk);
    set_port(2'd0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    #1;
    check("rd2 rvalid", 32'(bus.rvalid_o), 32'h1);
    check("rd2 rdata", bus.rdata_o, 32'hA5A5_0002);
    @(negedge clk);
    #1;
    check("rd idle rvalid", 32'(bus.rvalid_o), 32'h0);
    @(negedge clk);

    // port 2 partial write to 0x40, then read it back
    set_port(2'd2, 1'b1, 32'h40, 1'b1, 4'b0011, 32'hDEAD_BEEF);
    #1;
    check("wr gnt", 32'(bus.gnt_o), 32'h4);
    check("wr mem_we", 32'(bus.mem_we_o), 32'h1);
    check("wr mem_addr", bus.mem_addr_o, 32'h40);
    check("wr mem_be", 32'(bus.mem_be_o), 32'h3);
    check("wr mem_wdata", bus.mem_wdata_o, 32'hDEAD_BEEF);
    @(negedge clk);
    set_port(2'd2, 1'b1, 32'h40, 1'b0, 4'hF, 32'h0);
    #1;
    check("wr rvalid", 32'(bus.rvalid_o), 32'h4);
    check("rb gnt", 32'(bus.gnt_o), 32'h4);
    check("rb mem_we", 32'(bus.mem_we_o), 32'h0);
    @(negedge clk);
    set_port(2'd2, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    #1;
    check("rb rvalid", 32'(bus.rvalid_o), 32'h4);
    check("rb rdata", bus.rdata_o, 32'h1234_BEEF);
    @(negedge clk);

    // grant port 0 (rr_ptr -> 1), then reset while its response is in flight
    set_port(2'd0, 1'b1, 32'h100, 1'b0, 4'hF, 32'h0);
    #1;
    check("pre-rst gnt", 32'(bus.gnt_o), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    set_port(2'd1, 1'b1, 32'h104, 1'b0, 4'hF, 32'h0);
    #1;
    check("rst rvalid dropped", 32'(bus.rvalid_o), 32'h0);
    check("rst gnt", 32'(bus.gnt_o), 32'h0);
    check("rst mem_req", 32'(bus.mem_req_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-rst tie gnt", 32'(bus.gnt_o), 32'h1);
    check("post-rst mem_addr", bus.mem_addr_o, 32'h100);
    @(negedge clk);
    bus.req_i = 4'b0000;
    #1;
    check("post-rst rvalid", 32'(bus.rvalid_o), 32'h1);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
